// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals of the IF/LS memory arbiter.
// slave is the arbiter's view; master is the core-plus-memory side.
interface mem_arbiter_if #(
    parameter int unsigned AW = 20
);
    logic          if_req_i;
    logic [63:0]   if_addr_i;
    logic          if_ready_o;
    logic          if_valid_o;
    logic [31:0]   if_rdata_o;
    logic          if_err_o;

    logic          ls_req_i;
    logic          ls_we_i;
    logic [63:0]   ls_addr_i;
    logic [1:0]    ls_size_i;
    logic [63:0]   ls_wdata_i;
    logic          ls_ready_o;
    logic          ls_valid_o;
    logic [63:0]   ls_rdata_o;
    logic          ls_err_o;

    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [7:0]    mem_wstrb_o;
    logic [63:0]   mem_wdata_o;
    logic [63:0]   mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_ready_o, if_valid_o, if_rdata_o, if_err_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_size_i, ls_wdata_i,
        output ls_ready_o, ls_valid_o, ls_rdata_o, ls_err_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_ready_o, if_valid_o, if_rdata_o, if_err_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_size_i, ls_wdata_i,
        input  ls_ready_o, ls_valid_o, ls_rdata_o, ls_err_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One access at a time: IDLE -> ACCESS (MEM_LAT cycles) -> RESP, faults skip ACCESS.
module mem_arbiter #(
    parameter logic [63:0] PC_INIT = 64'h8000_0000,
    parameter int unsigned AW      = 20,
    parameter int unsigned MEM_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_last_ls, r_owner_ls, r_we, r_err;
    logic [2:0]    r_cnt;
    logic [AW-1:0] r_off;
    logic [1:0]    r_size;
    logic [63:0]   r_wdata, r_line;

    logic          w_if_win, w_ls_win, w_accept, w_misalign, w_fault;
    logic [63:0]   w_addr, w_off;
    logic [1:0]    w_size;
    logic          w_first, w_resp, w_last;
    logic [5:0]    w_lane;
    logic [7:0]    w_bmask;
    logic [63:0]   w_smask;

    // Arbitration and fault detection on the would-be winner.
    always_comb begin
        w_if_win = 1'b0;
        w_ls_win = 1'b0;
        if (r_state == StIdle && !rst) begin
            w_ls_win = bus.ls_req_i & (~bus.if_req_i | ~r_last_ls);
            w_if_win = bus.if_req_i & (~bus.ls_req_i | r_last_ls);
        end
        w_accept = w_if_win | w_ls_win;
        w_addr   = w_ls_win ? bus.ls_addr_i : bus.if_addr_i;
        w_size   = w_ls_win ? bus.ls_size_i : 2'd2;
        w_off    = w_addr - PC_INIT;
        case (w_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = w_addr[0];
            2'd2:    w_misalign = |w_addr[1:0];
            default: w_misalign = |w_addr[2:0];
        endcase
        w_fault = (|w_off[63:AW]) | w_misalign;
    end

    assign w_last = (r_cnt == LAT_M1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:   if (w_accept) w_state_nxt = w_fault ? StResp : StAccess;
            StAccess: if (w_last) w_state_nxt = StResp;
            StResp:   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_last_ls  <= 1'b0;
            r_owner_ls <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= 3'd0;
            r_off      <= '0;
            r_size     <= 2'd0;
            r_wdata    <= 64'd0;
            r_line     <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner_ls <= w_ls_win;
                r_last_ls  <= w_ls_win;
                r_we       <= w_ls_win & bus.ls_we_i;
                r_err      <= w_fault;
                r_off      <= w_off[AW-1:0];
                r_size     <= w_size;
                r_wdata    <= bus.ls_wdata_i;
                r_line     <= 64'd0;
                r_cnt      <= 3'd0;
            end else if (r_state == StAccess) begin
                if (w_last) r_line <= bus.mem_rdata_i;
                else r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        case (r_size)
            2'd0:    begin w_bmask = 8'h01; w_smask = 64'h0000_0000_0000_00ff; end
            2'd1:    begin w_bmask = 8'h03; w_smask = 64'h0000_0000_0000_ffff; end
            2'd2:    begin w_bmask = 8'h0f; w_smask = 64'h0000_0000_ffff_ffff; end
            default: begin w_bmask = 8'hff; w_smask = 64'hffff_ffff_ffff_ffff; end
        endcase
    end

    assign w_first = (r_state == StAccess) && (r_cnt == 3'd0);
    assign w_resp  = (r_state == StResp);
    assign w_lane  = {r_off[2:0], 3'b000};

    assign bus.if_ready_o  = w_if_win;
    assign bus.ls_ready_o  = w_ls_win;

    assign bus.mem_en_o    = w_first;
    assign bus.mem_we_o    = w_first & r_we;
    assign bus.mem_addr_o  = (r_state == StAccess) ? {r_off[AW-1:3], 3'b000} : '0;
    assign bus.mem_wstrb_o = (w_first & r_we) ? 8'(w_bmask << r_off[2:0]) : 8'h00;
    assign bus.mem_wdata_o = (w_first & r_we) ? (r_wdata << w_lane) : 64'd0;

    assign bus.if_valid_o  = w_resp & ~r_owner_ls;
    assign bus.ls_valid_o  = w_resp & r_owner_ls;
    assign bus.if_err_o    = w_resp & ~r_owner_ls & r_err;
    assign bus.ls_err_o    = w_resp & r_owner_ls & r_err;

    // Faulted and store responses carry zero data.
    assign bus.if_rdata_o  = (bus.if_valid_o & ~r_err) ?
                             (r_off[2] ? r_line[63:32] : r_line[31:0]) : 32'd0;
    assign bus.ls_rdata_o  = (bus.ls_valid_o & ~r_err & ~r_we) ?
                             ((r_line >> w_lane) & w_smask) : 64'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=1 instance driven from a vector table,
// MEM_LAT=3 instance for long-latency and reset-during-access sequences.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(20)) bus1 ();
    mem_arbiter_if #(.AW(20)) bus3 ();

    mem_arbiter #(.PC_INIT(64'h8000_0000), .AW(20), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    mem_arbiter #(.PC_INIT(64'h8000_0000), .AW(20), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    logic [63:0] mem1 [16];
    logic [63:0] mem3 [16];

    assign bus1.mem_rdata_i = mem1[bus1.mem_addr_o[6:3]];
    assign bus3.mem_rdata_i = mem3[bus3.mem_addr_o[6:3]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= 64'd0;
                mem3[i] <= 64'd0;
            end
            mem1[0]  <= 64'h1122_3344_5566_7788;
            mem1[1]  <= 64'h0123_4567_89ab_cdef;
            mem1[2]  <= 64'ha5a5_a5a5_5a5a_5a5a;
            mem1[15] <= 64'hcafe_babe_dead_beef;
            mem3[1]  <= 64'h0123_4567_89ab_cdef;
        end else if (bus1.mem_en_o && bus1.mem_we_o) begin
            for (int b = 0; b < 8; b++)
                if (bus1.mem_wstrb_o[b])
                    mem1[bus1.mem_addr_o[6:3]][8*b +: 8] <= bus1.mem_wdata_o[8*b +: 8];
        end
    end

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [63:0] wdata;
        int          lat;
        logic        err;
        logic [63:0] rdata;
        int          n_en;
        logic [19:0] maddr;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(logic is_ls, logic we, logic [63:0] addr, logic [1:0] size,
                                logic [63:0] wdata, int lat, logic err, logic [63:0] rdata,
                                int n_en, logic [19:0] maddr);
        vec_t v;
        v.is_ls = is_ls; v.we = we; v.addr = addr; v.size = size; v.wdata = wdata;
        v.lat = lat; v.err = err; v.rdata = rdata; v.n_en = n_en; v.maddr = maddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle1();
        bus1.if_req_i = 1'b0; bus1.if_addr_i = 64'd0;
        bus1.ls_req_i = 1'b0; bus1.ls_we_i = 1'b0; bus1.ls_addr_i = 64'd0;
        bus1.ls_size_i = 2'd0; bus1.ls_wdata_i = 64'd0;
    endtask

    task automatic idle3();
        bus3.if_req_i = 1'b0; bus3.if_addr_i = 64'd0;
        bus3.ls_req_i = 1'b0; bus3.ls_we_i = 1'b0; bus3.ls_addr_i = 64'd0;
        bus3.ls_size_i = 2'd0; bus3.ls_wdata_i = 64'd0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        int          n_en;
        logic        got;
        logic        other;
        logic        er;
        logic [63:0] rd;
        logic [19:0] maddr;
        @(negedge clk);
        bus1.if_req_i = ~v.is_ls; bus1.if_addr_i = v.addr;
        bus1.ls_req_i = v.is_ls;  bus1.ls_we_i = v.we; bus1.ls_addr_i = v.addr;
        bus1.ls_size_i = v.size;  bus1.ls_wdata_i = v.wdata;
        #1;
        chk($sformatf("v%0d_ready", idx), v.is_ls ? bus1.ls_ready_o : bus1.if_ready_o, 1);
        chk($sformatf("v%0d_other_ready", idx), v.is_ls ? bus1.if_ready_o : bus1.ls_ready_o, 0);
        @(negedge clk);
        idle1();
        bus1.ls_wdata_i = 64'hffff_ffff_ffff_ffff;
        #1;
        cyc = 1; n_en = 0; got = 1'b0; other = 1'b0; er = 1'b0; rd = 64'd0; maddr = '0;
        while (!got && cyc <= 10) begin
            if (bus1.mem_en_o) begin
                n_en++;
                maddr = bus1.mem_addr_o;
            end
            if (v.is_ls ? bus1.ls_valid_o : bus1.if_valid_o) begin
                got   = 1'b1;
                other = v.is_ls ? bus1.if_valid_o : bus1.ls_valid_o;
                er    = v.is_ls ? bus1.ls_err_o : bus1.if_err_o;
                rd    = v.is_ls ? bus1.ls_rdata_o : {32'd0, bus1.if_rdata_o};
            end else begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.lat));
        chk($sformatf("v%0d_err", idx), er, v.err);
        chk($sformatf("v%0d_rdata", idx), rd, v.rdata);
        chk($sformatf("v%0d_other_valid", idx), other, 0);
        chk($sformatf("v%0d_mem_en_count", idx), 64'(n_en), 64'(v.n_en));
        if (v.n_en != 0) chk($sformatf("v%0d_mem_addr", idx), 64'(maddr), 64'(v.maddr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        grants [4];
        int          n_gr;
        int          cyc;
        int          n_en;
        int          n_val;
        logic [63:0] rd;

        // Single-requester table (MEM_LAT = 1); loads of 0x..12/0x..10 follow the hand store.
        vecs[0]  = mk(0, 0, 64'h8000_0004, 2, 0, 2, 0, 64'h1122_3344, 1, 20'h00000);
        vecs[1]  = mk(0, 0, 64'h8000_0000, 2, 0, 2, 0, 64'h5566_7788, 1, 20'h00000);
        vecs[2]  = mk(1, 0, 64'h8000_0008, 3, 0, 2, 0, 64'h0123_4567_89ab_cdef, 1, 20'h00008);
        vecs[3]  = mk(1, 0, 64'h8000_0009, 0, 0, 2, 0, 64'hcd, 1, 20'h00008);
        vecs[4]  = mk(1, 0, 64'h8000_000c, 2, 0, 2, 0, 64'h0123_4567, 1, 20'h00008);
        vecs[5]  = mk(1, 0, 64'h8000_0002, 1, 0, 2, 0, 64'h5566, 1, 20'h00000);
        vecs[6]  = mk(1, 0, 64'h7fff_fff8, 3, 0, 1, 1, 64'd0, 0, 20'h00000);
        vecs[7]  = mk(0, 0, 64'h8000_0002, 2, 0, 1, 1, 64'd0, 0, 20'h00000);
        vecs[8]  = mk(1, 0, 64'h8010_0000, 2, 0, 1, 1, 64'd0, 0, 20'h00000);
        vecs[9]  = mk(1, 0, 64'h8000_0013, 1, 0, 1, 1, 64'd0, 0, 20'h00000);
        vecs[10] = mk(0, 0, 64'h800f_fffc, 2, 0, 2, 0, 64'hcafe_babe, 1, 20'hffff8);
        vecs[11] = mk(1, 0, 64'h8000_0012, 1, 0, 2, 0, 64'hbeef, 1, 20'h00010);
        vecs[12] = mk(1, 0, 64'h8000_0010, 3, 0, 2, 0, 64'ha5a5_a5a5_beef_5a5a, 1, 20'h00010);
        vecs[13] = mk(1, 1, 64'h8000_0020, 0, 64'h177, 2, 0, 64'd0, 1, 20'h00020);
        vecs[14] = mk(1, 0, 64'h8000_0020, 1, 0, 2, 0, 64'h0077, 1, 20'h00020);
        vecs[15] = mk(1, 0, 64'h8000_0021, 0, 0, 2, 0, 64'h00, 1, 20'h00020);
        vecs[16] = mk(0, 0, 64'h7fff_fffc, 2, 0, 1, 1, 64'd0, 0, 20'h00000);

        idle1();
        idle3();
        bus1.if_req_i = 1'b1; bus1.if_addr_i = 64'h8000_0000;
        bus1.ls_req_i = 1'b1; bus1.ls_addr_i = 64'h8000_0008; bus1.ls_size_i = 2'd3;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_if_ready", bus1.if_ready_o, 0);
        chk("rst_ls_ready", bus1.ls_ready_o, 0);
        chk("rst_mem_en", bus1.mem_en_o, 0);
        chk("rst_valids", {bus1.if_valid_o, bus1.ls_valid_o}, 0);

        // Continuous tie from reset: grants must alternate starting with LS.
        @(negedge clk);
        rst = 1'b0;
        n_gr = 0;
        for (int i = 0; i < 4; i++) grants[i] = 1'b0;
        for (int c = 0; c < 40 && n_gr < 4; c++) begin
            #1;
            if (bus1.if_ready_o || bus1.ls_ready_o) begin
                chk("tie_exclusive", bus1.if_ready_o & bus1.ls_ready_o, 0);
                grants[n_gr] = bus1.ls_ready_o;
                n_gr++;
            end
            @(negedge clk);
        end
        idle1();
        chk("tie_grant_count", 64'(n_gr), 4);
        chk("tie_grant0_ls", grants[0], 1);
        chk("tie_grant1_if", grants[1], 0);
        chk("tie_grant2_ls", grants[2], 1);
        chk("tie_grant3_if", grants[3], 0);
        repeat (4) @(negedge clk);

        // Halfword store at offset 0x12: strobes and lane shift.
        bus1.ls_req_i = 1'b1; bus1.ls_we_i = 1'b1; bus1.ls_addr_i = 64'h8000_0012;
        bus1.ls_size_i = 2'd1; bus1.ls_wdata_i = 64'hbeef;
        #1;
        chk("st_ready", bus1.ls_ready_o, 1);
        @(negedge clk);
        idle1();
        #1;
        chk("st_mem_en", bus1.mem_en_o, 1);
        chk("st_mem_we", bus1.mem_we_o, 1);
        chk("st_mem_addr", 64'(bus1.mem_addr_o), 64'h10);
        chk("st_wstrb", bus1.mem_wstrb_o, 8'b0000_1100);
        chk("st_wdata_lane", bus1.mem_wdata_o[31:16], 16'hbeef);
        @(negedge clk);
        #1;
        chk("st_valid", bus1.ls_valid_o, 1);
        chk("st_err", bus1.ls_err_o, 0);
        chk("st_rdata", bus1.ls_rdata_o, 0);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // MEM_LAT = 3 doubleword load.
        @(negedge clk);
        bus3.ls_req_i = 1'b1; bus3.ls_addr_i = 64'h8000_0008; bus3.ls_size_i = 2'd3;
        #1;
        chk("l3_ready", bus3.ls_ready_o, 1);
        @(negedge clk);
        idle3();
        #1;
        cyc = 1; n_en = 0; rd = 64'd0;
        while (!bus3.ls_valid_o && cyc <= 10) begin
            if (bus3.mem_en_o) n_en++;
            @(negedge clk);
            #1;
            cyc++;
        end
        rd = bus3.ls_rdata_o;
        chk("l3_latency", 64'(cyc), 4);
        chk("l3_mem_en_count", 64'(n_en), 1);
        chk("l3_rdata", rd, 64'h0123_4567_89ab_cdef);
        chk("l3_err", bus3.ls_err_o, 0);

        // Reset during ACCESS, with both requesters then held through reset.
        @(negedge clk);
        bus3.ls_req_i = 1'b1; bus3.ls_addr_i = 64'h8000_0008; bus3.ls_size_i = 2'd3;
        #1;
        chk("ra_ready", bus3.ls_ready_o, 1);
        @(negedge clk);
        #1;
        chk("ra_in_access", bus3.mem_en_o, 1);
        @(negedge clk);
        rst = 1'b1;
        bus3.if_req_i = 1'b1; bus3.if_addr_i = 64'h8000_0000;
        #1;
        chk("ra_ls_valid", bus3.ls_valid_o, 0);
        chk("ra_mem_addr", 64'(bus3.mem_addr_o), 0);
        chk("ra_readies", {bus3.if_ready_o, bus3.ls_ready_o}, 0);
        chk("ra_mem_en", bus3.mem_en_o, 0);
        n_val = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (bus3.ls_valid_o || bus3.if_valid_o) n_val++;
        end
        chk("ra_no_valid_in_reset", 64'(n_val), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ra_tie_ls_ready", bus3.ls_ready_o, 1);
        chk("ra_tie_if_ready", bus3.if_ready_o, 0);
        @(negedge clk);
        idle3();
        #1;
        cyc = 1;
        while (!bus3.ls_valid_o && cyc <= 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("ra_post_latency", 64'(cyc), 4);
        chk("ra_post_rdata", bus3.ls_rdata_o, 64'h0123_4567_89ab_cdef);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
